// File: rtl/ahb_mem_responder_if.sv
// AHB-Lite slave-side bus bundle for ahb_mem_responder.
//   master modport: the side that drives the transfer (address/control, write data
//                   and the muxed bus-level hready) and observes the slave response.
//   slave modport : the memory responder; consumes transfers and drives
//                   hrdata / hreadyout / hresp.
interface ahb_mem_responder_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hmastlock;
  logic        hready;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic [1:0]  hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hmastlock, hready,
    input  hrdata, hreadyout, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hmastlock, hready,
    output hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/ahb_mem_responder.sv
// AHB-Lite memory responder: word-organised on-chip RAM of 2**(ADDR_W-2) x 32 bits.
// Handles pipelined address/data phases, WAIT_STATES wait cycles per OKAY data
// phase, byte/halfword/word writes with lane enables and the two-cycle ERROR
// response for illegal size/alignment.
// Ports:
//   hclk   : bus clock, all state updates on the rising edge
//   hreset : synchronous active-high reset (memory contents are kept)
//   bus    : ahb_mem_responder_if.slave (hsel/haddr/htrans/hwrite/hsize/hburst/
//            hprot/hwdata/hmastlock/hready in; hrdata/hreadyout/hresp out)
module ahb_mem_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 1   // 0..7
) (
  input logic                hclk,
  input logic                hreset,
  ahb_mem_responder_if.slave bus
);

  localparam int unsigned Words = 2 ** (ADDR_W - 2);
  // Last count value of the wait counter; unused when WAIT_STATES is 0.
  localparam logic [2:0] WaitLast = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  localparam logic [1:0] RespOkay  = 2'b00;
  localparam logic [1:0] RespError = 2'b01;

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [2:0]        size_q;

  logic [31:0]       mem [Words];

  logic              addr_phase_ok;
  logic              accept;
  logic              err_in;
  logic [3:0]        be;
  logic              mem_we;
  logic [ADDR_W-3:0] word_idx;

  // Inputs with no effect on this responder.
  logic unused;
  assign unused = ^{bus.haddr[31:ADDR_W], bus.htrans[0], bus.hburst, bus.hprot,
                    bus.hmastlock};

  // An address phase may only be taken while this slave is not holding the bus
  // (WAIT/ERR1 drive hreadyout low, so hready is low there anyway).
  assign addr_phase_ok = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
  assign accept        = addr_phase_ok & bus.hsel & bus.hready & bus.htrans[1];

  always_comb begin
    err_in = 1'b0;
    if (bus.hsize > 3'd2) begin
      err_in = 1'b1;
    end else if (bus.hsize == 3'd1) begin
      err_in = bus.haddr[0];
    end else if (bus.hsize == 3'd2) begin
      err_in = (bus.haddr[1:0] != 2'b00);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StData, StErr2: begin
        // Data-phase completion and the next address phase overlap here.
        if (accept) begin
          cnt_d = 3'd0;
          if (err_in) begin
            state_d = StErr1;
          end else if (WAIT_STATES != 0) begin
            state_d = StWait;
          end else begin
            state_d = StData;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (cnt_q == WaitLast) begin
          state_d = StData;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StErr1: begin
        state_d = StErr2;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.hreadyout = 1'b1;
    bus.hresp     = RespOkay;
    bus.hrdata    = 32'h0;
    unique case (state_q)
      StWait: begin
        bus.hreadyout = 1'b0;
      end
      StData: begin
        if (!write_q) begin
          bus.hrdata = mem[word_idx];
        end
      end
      StErr1: begin
        bus.hreadyout = 1'b0;
        bus.hresp     = RespError;
      end
      StErr2: begin
        bus.hresp = RespError;
      end
      default: begin
        bus.hreadyout = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Address-phase capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge hclk) begin
    if (hreset) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
    end else if (accept) begin
      addr_q  <= bus.haddr[ADDR_W-1:0];
      write_q <= bus.hwrite;
      size_q  <= bus.hsize;
    end
  end

  assign word_idx = addr_q[ADDR_W-1:2];

  // ---------------------------------------------------------------------------
  // Write lanes and memory array
  // ---------------------------------------------------------------------------
  always_comb begin
    be = 4'b0000;
    unique case (size_q)
      3'd0:    be[addr_q[1:0]] = 1'b1;
      3'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Only legal transfers reach DATA, so errored writes never commit; a reset on
  // the commit edge also drops the write.
  assign mem_we = (state_q == StData) & write_q & ~hreset;

  always_ff @(posedge hclk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[word_idx][8*b +: 8] <= bus.hwdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_mem_responder.sv
module tb_ahb_mem_responder;

  logic hclk = 1'b0;
  logic hreset;
  always #5 hclk = ~hclk;

  // dut_sel picks which instance the stimulus targets: 0 -> WAIT_STATES=1, 1 -> 0.
  logic        dut_sel;
  logic        stall;
  logic        t_hsel;
  logic [31:0] t_haddr;
  logic [1:0]  t_htrans;
  logic        t_hwrite;
  logic [2:0]  t_hsize;
  logic [2:0]  t_hburst;
  logic [31:0] t_hwdata;

  int tests  = 0;
  int failed = 0;

  ahb_mem_responder_if bus1 ();
  ahb_mem_responder_if bus0 ();

  assign bus1.hsel      = t_hsel & ~dut_sel;
  assign bus1.haddr     = t_haddr;
  assign bus1.htrans    = t_htrans;
  assign bus1.hwrite    = t_hwrite;
  assign bus1.hsize     = t_hsize;
  assign bus1.hburst    = t_hburst;
  assign bus1.hprot     = 4'b0011;
  assign bus1.hwdata    = t_hwdata;
  assign bus1.hmastlock = 1'b0;
  assign bus1.hready    = bus1.hreadyout & ~stall;

  assign bus0.hsel      = t_hsel & dut_sel;
  assign bus0.haddr     = t_haddr;
  assign bus0.htrans    = t_htrans;
  assign bus0.hwrite    = t_hwrite;
  assign bus0.hsize     = t_hsize;
  assign bus0.hburst    = t_hburst;
  assign bus0.hprot     = 4'b0011;
  assign bus0.hwdata    = t_hwdata;
  assign bus0.hmastlock = 1'b0;
  assign bus0.hready    = bus0.hreadyout & ~stall;

  logic        o_hready;
  logic        o_hreadyout;
  logic [1:0]  o_hresp;
  logic [31:0] o_hrdata;
  assign o_hready    = dut_sel ? bus0.hready    : bus1.hready;
  assign o_hreadyout = dut_sel ? bus0.hreadyout : bus1.hreadyout;
  assign o_hresp     = dut_sel ? bus0.hresp     : bus1.hresp;
  assign o_hrdata    = dut_sel ? bus0.hrdata    : bus1.hrdata;

  ahb_mem_responder #(.ADDR_W(10), .WAIT_STATES(1)) u_dut1 (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus1)
  );

  ahb_mem_responder #(.ADDR_W(10), .WAIT_STATES(0)) u_dut0 (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single NONSEQ transfer; called and returns #1 after a rising edge.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                      input logic [31:0] wdata, output logic [31:0] rd,
                      output logic [1:0] resp, output logic [1:0] resp1,
                      output logic rdy1, output int waits);
    t_hsel   = 1'b1;
    t_haddr  = addr;
    t_htrans = 2'b10;
    t_hwrite = wr;
    t_hsize  = size;
    t_hburst = 3'b000;
    @(posedge hclk); #1;
    t_hsel   = 1'b0;
    t_htrans = 2'b00;
    t_hwdata = wdata;
    waits    = 0;
    @(negedge hclk);
    resp1 = o_hresp;
    rdy1  = o_hreadyout;
    while (!o_hreadyout && waits < 20) begin
      waits++;
      @(negedge hclk);
    end
    rd   = o_hrdata;
    resp = o_hresp;
    @(posedge hclk); #1;
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata, input int exp_waits);
    logic [31:0] rd;
    logic [1:0]  resp, resp1;
    logic        rdy1;
    int          waits;
    xfer(addr, 1'b1, size, wdata, rd, resp, resp1, rdy1, waits);
    chk({tag, "_resp"}, {30'd0, resp}, 32'h0);
    chk({tag, "_waits"}, 32'(waits), 32'(exp_waits));
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                         input int exp_waits);
    logic [31:0] rd;
    logic [1:0]  resp, resp1;
    logic        rdy1;
    int          waits;
    xfer(addr, 1'b0, 3'd2, 32'h0, rd, resp, resp1, rdy1, waits);
    chk({tag, "_data"}, rd, exp);
    chk({tag, "_resp"}, {30'd0, resp}, 32'h0);
    chk({tag, "_waits"}, 32'(waits), 32'(exp_waits));
  endtask

  // Four-beat INCR word burst with address/data pipelining.
  task automatic burst(input logic [31:0] base, input logic wr, input logic [3:0][31:0] d,
                       output logic [3:0][31:0] r, output int cycles);
    int   ab;
    int   db;
    logic rdy;
    ab     = 0;
    db     = -1;
    cycles = 0;
    r      = '0;
    while ((ab < 4 || db >= 0) && cycles < 60) begin
      if (ab < 4) begin
        t_hsel   = 1'b1;
        t_htrans = (ab == 0) ? 2'b10 : 2'b11;
        t_haddr  = base + 32'(4 * ab);
        t_hwrite = wr;
        t_hsize  = 3'd2;
        t_hburst = 3'b011;
      end else begin
        t_hsel   = 1'b0;
        t_htrans = 2'b00;
      end
      if (db >= 0) t_hwdata = d[db];
      @(negedge hclk);
      rdy = o_hready;
      if (rdy && db >= 0 && !wr) r[db] = o_hrdata;
      @(posedge hclk); #1;
      cycles++;
      if (rdy) begin
        db = (ab < 4) ? ab : -1;
        if (ab < 4) ab++;
      end
    end
    t_hsel   = 1'b0;
    t_htrans = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0]       rd;
    logic [1:0]        resp, resp1;
    logic              rdy1;
    int                waits;
    int                cycles;
    logic [3:0][31:0]  bd;
    logic [3:0][31:0]  br;

    dut_sel  = 1'b0;
    stall    = 1'b0;
    t_hsel   = 1'b0;
    t_haddr  = 32'h0;
    t_htrans = 2'b00;
    t_hwrite = 1'b0;
    t_hsize  = 3'd0;
    t_hburst = 3'd0;
    t_hwdata = 32'h0;
    hreset   = 1'b1;
    @(posedge hclk); @(posedge hclk); #1;
    hreset = 1'b0;
    @(negedge hclk);
    chk("rst_hreadyout", {31'd0, o_hreadyout}, 32'h1);
    chk("rst_hresp", {30'd0, o_hresp}, 32'h0);
    chk("rst_hrdata", o_hrdata, 32'h0);
    @(posedge hclk); #1;

    // Reset in the middle of a write's wait state drops the write.
    do_write("t1_pre", 32'h040, 3'd2, 32'h11111111, 1);
    t_hsel   = 1'b1;
    t_haddr  = 32'h040;
    t_htrans = 2'b10;
    t_hwrite = 1'b1;
    t_hsize  = 3'd2;
    @(posedge hclk); #1;
    t_hsel   = 1'b0;
    t_htrans = 2'b00;
    t_hwdata = 32'h22222222;
    hreset   = 1'b1;
    @(negedge hclk);
    chk("t1_in_wait", {31'd0, o_hreadyout}, 32'h0);
    @(posedge hclk); @(posedge hclk); #1;
    hreset = 1'b0;
    @(negedge hclk);
    chk("t1_hreadyout", {31'd0, o_hreadyout}, 32'h1);
    chk("t1_hresp", {30'd0, o_hresp}, 32'h0);
    chk("t1_hrdata", o_hrdata, 32'h0);
    @(posedge hclk); #1;
    do_read("t1_rd", 32'h040, 32'h11111111, 1);

    // Word write/read with one wait state per data phase.
    do_write("t2_wr", 32'h010, 3'd2, 32'hDEADBEEF, 1);
    do_read("t2_rd", 32'h010, 32'hDEADBEEF, 1);

    // Byte and halfword lane writes.
    do_write("t3_wrb", 32'h011, 3'd0, 32'h0000AA00, 1);
    do_read("t3_rdb", 32'h010, 32'hDEADAAEF, 1);
    do_write("t3_wrw", 32'h014, 3'd2, 32'h55555555, 1);
    do_write("t3_wrh", 32'h016, 3'd1, 32'h12340000, 1);
    do_read("t3_rdh", 32'h014, 32'h12345555, 1);
    do_write("t3_wrb0", 32'h014, 3'd0, 32'h000000C3, 1);
    do_read("t3_rdb0", 32'h014, 32'h123455C3, 1);

    // Misaligned and oversized transfers take the two-cycle ERROR response.
    xfer(32'h012, 1'b0, 3'd2, 32'h0, rd, resp, resp1, rdy1, waits);
    chk("t4_rd_c1_ready", {31'd0, rdy1}, 32'h0);
    chk("t4_rd_c1_resp", {30'd0, resp1}, 32'h1);
    chk("t4_rd_c2_resp", {30'd0, resp}, 32'h1);
    chk("t4_rd_waits", 32'(waits), 32'h1);
    xfer(32'h012, 1'b1, 3'd2, 32'hFFFFFFFF, rd, resp, resp1, rdy1, waits);
    chk("t4_wr_resp", {30'd0, resp}, 32'h1);
    xfer(32'h011, 1'b1, 3'd1, 32'hFFFFFFFF, rd, resp, resp1, rdy1, waits);
    chk("t4_half_resp", {30'd0, resp}, 32'h1);
    xfer(32'h010, 1'b1, 3'd3, 32'hFFFFFFFF, rd, resp, resp1, rdy1, waits);
    chk("t4_size3_resp", {30'd0, resp}, 32'h1);
    do_read("t4_unchanged", 32'h010, 32'hDEADAAEF, 1);

    // INCR4 bursts, pipelined.
    bd = {32'h4, 32'h3, 32'h2, 32'h1};
    burst(32'h020, 1'b1, bd, br, cycles);
    chk("t5_wr_cycles", 32'(cycles), 32'd9);
    burst(32'h020, 1'b0, bd, br, cycles);
    chk("t5_rd_cycles", 32'(cycles), 32'd9);
    chk("t5_rd0", br[0], 32'h1);
    chk("t5_rd1", br[1], 32'h2);
    chk("t5_rd2", br[2], 32'h3);
    chk("t5_rd3", br[3], 32'h4);
    // Address bits above ADDR_W wrap within the memory.
    do_read("t5_wrap", 32'h0000_0424, 32'h2, 1);

    dut_sel = 1'b1;
    bd = {32'h8, 32'h7, 32'h6, 32'h5};
    burst(32'h020, 1'b1, bd, br, cycles);
    chk("t5z_wr_cycles", 32'(cycles), 32'd5);
    burst(32'h020, 1'b0, bd, br, cycles);
    chk("t5z_rd_cycles", 32'(cycles), 32'd5);
    chk("t5z_rd0", br[0], 32'h5);
    chk("t5z_rd3", br[3], 32'h8);
    do_read("t5z_single", 32'h024, 32'h6, 0);
    dut_sel = 1'b0;

    // Unselected / IDLE / BUSY / foreign-stall address phases are not taken.
    t_hsel   = 1'b0;
    t_haddr  = 32'h010;
    t_htrans = 2'b10;
    t_hwrite = 1'b1;
    t_hsize  = 3'd2;
    @(posedge hclk); #1;
    t_htrans = 2'b00;
    t_hwdata = 32'hFFFFFFFF;
    @(negedge hclk);
    chk("t6_nosel_ready", {31'd0, o_hreadyout}, 32'h1);
    chk("t6_nosel_resp", {30'd0, o_hresp}, 32'h0);
    @(posedge hclk); #1;

    t_hsel   = 1'b1;
    t_htrans = 2'b01;
    @(posedge hclk); #1;
    t_hsel   = 1'b0;
    t_htrans = 2'b00;
    @(negedge hclk);
    chk("t6_busy_ready", {31'd0, o_hreadyout}, 32'h1);
    chk("t6_busy_resp", {30'd0, o_hresp}, 32'h0);
    @(posedge hclk); #1;

    t_hsel   = 1'b1;
    t_htrans = 2'b10;
    stall    = 1'b1;
    @(posedge hclk); #1;
    stall    = 1'b0;
    t_hsel   = 1'b0;
    t_htrans = 2'b00;
    @(negedge hclk);
    chk("t6_stall_ready", {31'd0, o_hreadyout}, 32'h1);
    @(posedge hclk); #1;
    do_read("t6_unchanged", 32'h010, 32'hDEADAAEF, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
